// File: rtl/axis_uart_reg_bridge_pkg.sv
// Shared opcodes, reply codes and FSM state type for the UART register bridge.
package uart_reg_bridge_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        READ,
        RWAIT,
        RESP
    } state_t;

    // One UART byte-time is 10 bit-times (start + 8 data + stop).
    function automatic int unsigned timeout_cycles(input int unsigned clock,
                                                   input int unsigned baud,
                                                   input int unsigned nbytes);
        return (clock / baud) * 10 * nbytes;
    endfunction

endpackage

// File: rtl/axis_uart_reg_bridge_if.sv
// Minimal AXI-Stream byte channel with master and slave views.
interface axis_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport m_axis (output tdata, output tvalid, input tready);
    modport s_axis (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_reg_bridge_timer.sv
// Inter-byte timeout counter; expired pulses once LIMIT idle cycles pass while running.
module uart_reg_bridge_timer #(
    parameter int unsigned LIMIT = 34_720
) (
    input  logic aclk,
    input  logic areset,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expired
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_count <= '0;
        end else if (i_clr || !i_run) begin
            r_count <= '0;
        end else if (!o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_run && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/axis_uart_reg_bridge.sv
// Parses W/R command frames from the UART RX stream, drives a 32-bit register
// bus and streams ACK/NAK or read data back to the UART TX side.
module axis_uart_reg_bridge
    import uart_reg_bridge_pkg::*;
#(
    parameter int unsigned CLOCK         = 100_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter int unsigned TIMEOUT_BYTES = 4,
    parameter int unsigned ADDR_W        = 8
) (
    input  logic              aclk,
    input  logic              areset,
    axis_if.s_axis            s_axis,
    axis_if.m_axis            m_axis,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [31:0]       o_reg_wdata,
    output logic              o_reg_wr,
    output logic              o_reg_rd,
    input  logic [31:0]       i_reg_rdata
);
    localparam int unsigned TIMEOUT_LIMIT = timeout_cycles(CLOCK, BAUD_RATE, TIMEOUT_BYTES);

    state_t            r_state;
    logic              r_is_read;
    logic [1:0]        r_byte_cnt;
    logic [39:0]       r_shift;
    logic [2:0]        r_resp_left;
    logic              r_tready;
    logic              r_tvalid;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [31:0]       r_reg_wdata;
    logic              r_reg_wr;
    logic              r_reg_rd;

    logic              w_accept;
    logic              w_run;
    logic              w_expired;

    assign w_accept = s_axis.tvalid && r_tready;
    assign w_run    = (r_state == ADDR) || (r_state == WDATA);

    uart_reg_bridge_timer #(
        .LIMIT (TIMEOUT_LIMIT)
    ) u_timer (
        .aclk      (aclk),
        .areset    (areset),
        .i_clr     (w_accept),
        .i_run     (w_run),
        .o_expired (w_expired)
    );

    // The reply byte on the wire is always the top byte of the shift register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= IDLE;
            r_is_read   <= 1'b0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_resp_left <= '0;
            r_tready    <= 1'b0;
            r_tvalid    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
        end else begin
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tready <= 1'b1;
                    if (w_accept) begin
                        if (s_axis.tdata == OP_WR || s_axis.tdata == OP_RD) begin
                            r_is_read <= (s_axis.tdata == OP_RD);
                            r_state   <= ADDR;
                        end else begin
                            r_tready    <= 1'b0;
                            r_tvalid    <= 1'b1;
                            r_shift     <= {RSP_NAK, 32'h0};
                            r_resp_left <= 3'd1;
                            r_state     <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (w_accept) begin
                        r_reg_addr <= ADDR_W'(s_axis.tdata);
                        r_byte_cnt <= '0;
                        if (r_is_read) begin
                            r_tready <= 1'b0;
                            r_reg_rd <= 1'b1;
                            r_state  <= READ;
                        end else begin
                            r_state <= WDATA;
                        end
                    end else if (w_expired) begin
                        r_state <= IDLE;
                    end
                end
                WDATA: begin
                    if (w_accept) begin
                        r_reg_wdata <= {r_reg_wdata[23:0], s_axis.tdata};
                        r_byte_cnt  <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_tready <= 1'b0;
                            r_reg_wr <= 1'b1;
                            r_state  <= WRITE;
                        end
                    end else if (w_expired) begin
                        r_state <= IDLE;
                    end
                end
                WRITE: begin
                    r_tvalid    <= 1'b1;
                    r_shift     <= {RSP_ACK, 32'h0};
                    r_resp_left <= 3'd1;
                    r_state     <= RESP;
                end
                READ: begin
                    r_state <= RWAIT;
                end
                RWAIT: begin
                    r_tvalid    <= 1'b1;
                    r_shift     <= {OP_RD, i_reg_rdata};
                    r_resp_left <= 3'd5;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (r_tvalid && m_axis.tready) begin
                        r_shift <= {r_shift[31:0], 8'h00};
                        if (r_resp_left == 3'd1) begin
                            r_tvalid <= 1'b0;
                            r_tready <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_resp_left <= r_resp_left - 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_axis.tready = r_tready;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_shift[39:32];
    assign o_reg_addr    = r_reg_addr;
    assign o_reg_wdata   = r_reg_wdata;
    assign o_reg_wr      = r_reg_wr;
    assign o_reg_rd      = r_reg_rd;

endmodule

// File: tb/tb_axis_uart_reg_bridge.sv
// Directed bench for axis_uart_reg_bridge: a table of command frames with their
// expected replies, followed by hand-written stall, timeout and reset sequences.
module tb_axis_uart_reg_bridge;

    // 1_152_000 / 115_200 = 10 clocks per bit -> 10 * 10 * 4 = 400-cycle timeout
    localparam int unsigned CLK_HZ = 1_152_000;
    localparam int unsigned BAUD   = 115_200;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axis_if rxIf ();
    axis_if txIf ();

    logic [7:0]  regAddr;
    logic [31:0] regWdata;
    logic [31:0] regRdata = 32'hBAD0_BAD0;
    logic        regWr;
    logic        regRd;

    axis_uart_reg_bridge #(
        .CLOCK         (CLK_HZ),
        .BAUD_RATE     (BAUD),
        .TIMEOUT_BYTES (4),
        .ADDR_W        (8)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_axis      (rxIf),
        .m_axis      (txIf),
        .o_reg_addr  (regAddr),
        .o_reg_wdata (regWdata),
        .o_reg_wr    (regWr),
        .o_reg_rd    (regRd),
        .i_reg_rdata (regRdata)
    );

    typedef struct packed {
        logic [47:0] frame;
        int          frameLen;
        logic [31:0] rdata;
        logic        toggle;
        logic [39:0] reply;
        int          replyLen;
        logic        expWr;
        logic        expRd;
        logic [7:0]  expAddr;
        logic [31:0] expWdata;
    } vec_t;

    vec_t vecs [6];

    int          checks     = 0;
    int          failures   = 0;
    int          cyc        = 0;
    int          lastAccept = 0;
    int          lastTxEdge = 0;
    int          wrEdge     = 0;
    int          rdEdge     = 0;
    int          tvRise     = 0;
    int          wrCnt      = 0;
    int          rdCnt      = 0;
    int          bothErr    = 0;
    int          stableErr  = 0;
    int          readyMode  = 2;
    logic [7:0]  capAddr    = 8'h00;
    logic [31:0] capWdata   = 32'h0;
    logic [31:0] rdataVal   = 32'h0;
    logic        rdSeen     = 1'b0;
    logic        prevTv     = 1'b0;
    logic        prevTr     = 1'b0;
    logic [7:0]  prevTd     = 8'h00;
    logic [7:0]  txQ [$];

    // Register responder: read data is valid only in the cycle after reg_rd,
    // junk otherwise, so a wrongly timed capture shows up in the reply.
    always @(posedge aclk) begin
        cyc++;
        #1;
        regRdata = rdSeen ? rdataVal : 32'hBAD0_BAD0;
        rdSeen   = 1'b0;
    end

    // Downstream ready: 0 = always ready, 1 = toggle every cycle, 2 = manual.
    always @(posedge aclk) begin
        #1;
        if (readyMode == 0) begin
            txIf.tready = 1'b1;
        end else if (readyMode == 1) begin
            txIf.tready = ~txIf.tready;
        end
    end

    // Monitor at negedge: handshakes seen here complete at the next posedge,
    // so edge stamps are cyc+1; a latency of N means N edges between stamps.
    always @(negedge aclk) begin
        if (areset) begin
            prevTv = 1'b0;
        end else begin
            if (rxIf.tvalid && rxIf.tready) lastAccept = cyc + 1;
            if (txIf.tvalid && txIf.tready) begin
                txQ.push_back(txIf.tdata);
                lastTxEdge = cyc + 1;
            end
            if (txIf.tvalid && !prevTv) tvRise = cyc + 1;
            if (prevTv && !prevTr && (!txIf.tvalid || txIf.tdata != prevTd)) stableErr++;
            if (regWr) begin
                wrCnt++;
                wrEdge   = cyc + 1;
                capAddr  = regAddr;
                capWdata = regWdata;
            end
            if (regRd) begin
                rdCnt++;
                rdEdge  = cyc + 1;
                capAddr = regAddr;
                rdSeen  = 1'b1;
            end
            if (regWr && regRd) bothErr++;
            prevTv = txIf.tvalid;
            prevTr = txIf.tready;
            prevTd = txIf.tdata;
        end
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Present one byte on the RX stream and hold it until accepted.
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [7:0] b);
        bit taken = 1'b0;
        rxIf.tdata  = b;
        rxIf.tvalid = 1'b1;
        for (int n = 0; n < 1000 && !taken; n++) begin
            @(negedge aclk);
            if (rxIf.tready) taken = 1'b1;
        end
        if (!taken) begin
            checks++;
            failures++;
            $display("[TB] FAIL acceptTimeout: byte %0h not accepted, required acceptance", b);
        end
        @(posedge aclk);
        #1;
        rxIf.tvalid = 1'b0;
    endtask

    task automatic waitReply(input int n);
        int k = 0;
        while (txQ.size() < n && k < 300) begin
            @(negedge aclk);
            k++;
        end
        repeat (6) @(posedge aclk);
        #1;
    endtask

    task automatic clearMonitors();
        txQ.delete();
        wrCnt     = 0;
        rdCnt     = 0;
        stableErr = 0;
    endtask

    task automatic checkReply(input string tag, input logic [47:0] expBytes, input int expLen);
        logic [7:0] got;
        checkOutput({tag, ".replyLen"}, 40'(txQ.size()), 40'(expLen));
        for (int i = 0; i < expLen; i++) begin
            got = 8'hxx;
            if (i < txQ.size()) got = txQ[i];
            checkOutput($sformatf("%s.byte%0d", tag, i), 40'(got), 40'(expBytes[47-8*i -: 8]));
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        clearMonitors();
        readyMode = v.toggle ? 1 : 0;
        rdataVal  = v.rdata;
        for (int i = 0; i < v.frameLen; i++) applyStimulus(v.frame[47-8*i -: 8]);
        waitReply(v.replyLen);
        checkReply(tag, {v.reply, 8'h00}, v.replyLen);
        checkOutput({tag, ".wrCount"}, 40'(wrCnt), 40'(v.expWr));
        checkOutput({tag, ".rdCount"}, 40'(rdCnt), 40'(v.expRd));
        checkOutput({tag, ".tdataStable"}, 40'(stableErr), 40'd0);
        if (v.expWr) begin
            checkOutput({tag, ".addr"}, 40'(capAddr), 40'(v.expAddr));
            checkOutput({tag, ".wdata"}, 40'(capWdata), 40'(v.expWdata));
            checkOutput({tag, ".wrLatency"}, 40'(wrEdge - lastAccept), 40'd1);
            checkOutput({tag, ".ackLatency"}, 40'(tvRise - lastAccept), 40'd2);
        end
        if (v.expRd) begin
            checkOutput({tag, ".addr"}, 40'(capAddr), 40'(v.expAddr));
            checkOutput({tag, ".rdLatency"}, 40'(rdEdge - lastAccept), 40'd1);
            checkOutput({tag, ".replyLatency"}, 40'(tvRise - lastAccept), 40'd3);
        end
    endtask

    function automatic vec_t mkVec(input logic [47:0] f, input int fl, input logic [31:0] rd,
                                   input logic tg, input logic [39:0] rp, input int rl,
                                   input logic ew, input logic er, input logic [7:0] ea,
                                   input logic [31:0] ed);
        vec_t v;
        v.frame    = f;
        v.frameLen = fl;
        v.rdata    = rd;
        v.toggle   = tg;
        v.reply    = rp;
        v.replyLen = rl;
        v.expWr    = ew;
        v.expRd    = er;
        v.expAddr  = ea;
        v.expWdata = ed;
        return v;
    endfunction

    initial begin
        rxIf.tvalid = 1'b0;
        rxIf.tdata  = 8'h00;
        txIf.tready = 1'b0;

        vecs[0] = mkVec(48'h57_10_DE_AD_BE_EF, 6, 32'h0,        1'b0, 40'h06_00000000, 1, 1'b1, 1'b0, 8'h10, 32'hDEAD_BEEF);
        vecs[1] = mkVec(48'h52_20_00000000,    2, 32'h1234_5678, 1'b0, 40'h52_12345678, 5, 1'b0, 1'b1, 8'h20, 32'h0);
        vecs[2] = mkVec(48'h52_21_00000000,    2, 32'hA5C3_0F96, 1'b1, 40'h52_A5C30F96, 5, 1'b0, 1'b1, 8'h21, 32'h0);
        vecs[3] = mkVec(48'h41_00_00000000,    1, 32'h0,        1'b0, 40'h15_00000000, 1, 1'b0, 1'b0, 8'h00, 32'h0);
        vecs[4] = mkVec(48'h57_01_00_00_00_05, 6, 32'h0,        1'b0, 40'h06_00000000, 1, 1'b1, 1'b0, 8'h01, 32'h0000_0005);
        vecs[5] = mkVec(48'hFF_00_00000000,    1, 32'h0,        1'b0, 40'h15_00000000, 1, 1'b0, 1'b0, 8'h00, 32'h0);

        repeat (3) @(posedge aclk);
        #1;
        checkOutput("reset.mTvalid", 40'(txIf.tvalid), 40'd0);
        checkOutput("reset.mTdata", 40'(txIf.tdata), 40'd0);
        checkOutput("reset.sTready", 40'(rxIf.tready), 40'd0);
        checkOutput("reset.regWr", 40'(regWr), 40'd0);
        checkOutput("reset.regRd", 40'(regRd), 40'd0);
        checkOutput("reset.regAddr", 40'(regAddr), 40'd0);
        checkOutput("reset.regWdata", 40'(regWdata), 40'd0);
        areset    = 1'b0;
        readyMode = 0;
        @(posedge aclk);
        #1;
        checkOutput("idle.sTready", 40'(rxIf.tready), 40'd1);

        for (int i = 0; i < 6; i++) runVector(vecs[i], i);

        // Back-to-back: the read opcode lands the cycle after the NAK handshake.
        clearMonitors();
        rdataVal = 32'h0F1E_2D3C;
        applyStimulus(8'h41);
        applyStimulus(8'h52);
        checkOutput("b2b.opcodeGap", 40'(lastAccept - lastTxEdge), 40'd1);
        applyStimulus(8'h33);
        waitReply(6);
        checkReply("b2b", 48'h15_52_0F_1E_2D_3C, 6);
        checkOutput("b2b.addr", 40'(capAddr), 40'h33);

        // Downstream stalled far longer than the timeout: reply must be held.
        clearMonitors();
        readyMode   = 2;
        txIf.tready = 1'b0;
        applyStimulus(8'h41);
        repeat (500) @(posedge aclk);
        #1;
        checkOutput("stall.mTvalid", 40'(txIf.tvalid), 40'd1);
        checkOutput("stall.mTdata", 40'(txIf.tdata), 40'h15);
        checkOutput("stall.sTready", 40'(rxIf.tready), 40'd0);
        readyMode = 0;
        waitReply(1);
        checkReply("stall", 48'h15_0000000000, 1);

        // Gaps just under the timeout keep the frame alive.
        clearMonitors();
        applyStimulus(8'h57);
        applyStimulus(8'h11);
        for (int i = 1; i <= 4; i++) begin
            repeat (350) @(posedge aclk);
            #1;
            applyStimulus(8'(i));
        end
        waitReply(1);
        checkReply("slowWr", 48'h06_0000000000, 1);
        checkOutput("slowWr.wdata", 40'(capWdata), 40'h01020304);
        checkOutput("slowWr.wrCount", 40'(wrCnt), 40'd1);

        // Partial frame abandoned after the timeout; next read still works.
        clearMonitors();
        applyStimulus(8'h57);
        applyStimulus(8'h10);
        applyStimulus(8'hAA);
        repeat (450) @(posedge aclk);
        #1;
        checkOutput("timeout.replyLen", 40'(txQ.size()), 40'd0);
        checkOutput("timeout.wrCount", 40'(wrCnt), 40'd0);
        rdataVal = 32'h600D_F00D;
        applyStimulus(8'h52);
        applyStimulus(8'h10);
        waitReply(5);
        checkReply("timeout.read", 48'h52_60_0D_F0_0D_00, 5);
        checkOutput("timeout.rdCount", 40'(rdCnt), 40'd1);
        checkOutput("timeout.wrCount2", 40'(wrCnt), 40'd0);
        checkOutput("timeout.addr", 40'(capAddr), 40'h10);

        // Reset while the third read-reply byte is waiting for tready.
        clearMonitors();
        readyMode   = 2;
        txIf.tready = 1'b0;
        rdataVal    = 32'hCAFE_F00D;
        applyStimulus(8'h52);
        applyStimulus(8'h30);
        for (int n = 0; n < 50 && !txIf.tvalid; n++) @(negedge aclk);
        checkOutput("rst.firstByte", 40'(txIf.tdata), 40'h52);
        for (int i = 0; i < 2; i++) begin
            @(posedge aclk);
            #1 txIf.tready = 1'b1;
            @(posedge aclk);
            #1 txIf.tready = 1'b0;
        end
        @(negedge aclk);
        checkOutput("rst.thirdByte", 40'(txIf.tdata), 40'hFE);
        checkOutput("rst.thirdValid", 40'(txIf.tvalid), 40'd1);
        #2 areset = 1'b1;
        #1;
        checkOutput("rst.mTvalid", 40'(txIf.tvalid), 40'd0);
        checkOutput("rst.mTdata", 40'(txIf.tdata), 40'd0);
        checkOutput("rst.sTready", 40'(rxIf.tready), 40'd0);
        checkOutput("rst.bytesSent", 40'(txQ.size()), 40'd2);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        clearMonitors();
        readyMode = 0;
        for (int i = 0; i < 6; i++) applyStimulus((i == 0) ? 8'h57 : ((i == 5) ? 8'h01 : 8'h00));
        waitReply(1);
        checkReply("rst.write", 48'h06_0000000000, 1);
        checkOutput("rst.wdata", 40'(capWdata), 40'h1);
        checkOutput("rst.wrCount", 40'(wrCnt), 40'd1);

        checkOutput("strobeOverlap", 40'(bothErr), 40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
